// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types and constants for the pipeline hazard control
//                slice (MD FSM encoding, register-zero index, NOP word).
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Multiply/divide occupancy FSM
    typedef enum logic {
        RUN    = 1'b0,
        MDWAIT = 1'b1
    } md_state_e;

    // Architectural zero register: never a real producer
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Control word injected by the bubble/flush muxes (all-zero = no side effects)
    localparam logic [31:0] NOP_CTRL = 32'h0000_0000;

    // True when the consumer actually reads a register that matches the producer
    function automatic logic src_hit(input logic [4:0] src, input logic src_used,
                                     input logic [4:0] dst);
        return src_used && (src == dst);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_cycle_counter.sv
`default_nettype none
// ============================================================================
//  Module      : md_cycle_counter
//  Description : Loadable 8-bit down-counter that times multiply/divide
//                occupancy of EX. Stops at zero; zero flag is combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_cycle_counter
    import pipe_ctrl_pkg::*;
(
    input  logic       Clk,
    input  logic       Clrn,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: load wins over decrement; never wraps below zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // Count register with asynchronous clear
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 8'd0);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Stall/flush sequencer for the 5-stage pipeline. Resolves
//                multiply/divide occupancy, load-use hazards and taken-branch
//                flushes (in that priority) and counts stall cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_CYCLES = 32,
    parameter int PERF_W    = 16
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [4:0]        ex_rn,
    input  logic              ex_wreg,
    input  logic              ex_m2reg,
    input  logic              branch_taken,
    input  logic              md_start,
    input  logic              perf_clr,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_bubble,
    output logic              exmem_bubble,
    output logic              md_busy,
    output logic              md_done,
    output logic [PERF_W-1:0] stall_cycles
);

    // The first stall cycle happens in RUN, so the counter covers the rest
    localparam logic [7:0]        MD_LOAD  = 8'(MD_CYCLES - 1);
    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    md_state_e         state_q;
    md_state_e         state_d;
    logic              cnt_zero;
    logic              cnt_load;
    logic              cnt_dec;
    logic              lu;
    logic              md_stall;
    logic [PERF_W-1:0] perf_q;
    logic [PERF_W-1:0] perf_d;

    assign lu = ex_wreg && ex_m2reg && (ex_rn != REG_ZERO) &&
                (src_hit(id_rs, id_use_rs, ex_rn) || src_hit(id_rt, id_use_rt, ex_rn));

    assign md_stall = ((state_q == RUN) && md_start) ||
                      ((state_q == MDWAIT) && !cnt_zero);

    assign cnt_load = (state_q == RUN) && md_start;
    assign cnt_dec  = (state_q == MDWAIT) && !cnt_zero;

    md_cycle_counter u_md_cnt (
        .Clk      (Clk),
        .Clrn     (Clrn),
        .load     (cnt_load),
        .load_val (MD_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // MD FSM next state; md_start is ignored while in MDWAIT (same op still asserts it)
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (md_start) state_d = MDWAIT;
            MDWAIT:  if (cnt_zero) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // MD FSM state register
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Pipeline-register control decode; everything idles low while in reset
    always_comb begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        ifid_flush   = 1'b0;
        idex_en      = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        md_busy      = 1'b0;
        md_done      = 1'b0;
        if (Clrn) begin
            md_busy = (state_q == MDWAIT);
            md_done = (state_q == MDWAIT) && cnt_zero;
            if (md_stall) begin
                exmem_bubble = 1'b1;
            end else if (lu) begin
                idex_en     = 1'b1;
                idex_bubble = 1'b1;
            end else if (branch_taken) begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                ifid_flush = 1'b1;
            end else begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
                idex_en = 1'b1;
            end
        end
    end

    // Stall counter next value: clear beats increment, saturates at all-ones
    always_comb begin
        perf_d = perf_q;
        if (perf_clr) begin
            perf_d = '0;
        end else if (!pc_en && (perf_q != PERF_MAX)) begin
            perf_d = perf_q + 1'b1;
        end
    end

    // Stall counter register
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign stall_cycles = perf_q;

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Drives the enable and bubble/flush selects of the PC, IF/ID, ID/EX and EX/MEM pipeline registers (banks of enable-capable D flip-flops). Handles three conditions:
- load-use hazards;
- taken-branch flushes;
- multi-cycle multiply/divide occupancy of EX.
Also keeps a stall-cycle performance counter.

Parameters:
MD_CYCLES, 32, total stall cycles for one multiply/divide op; legal range 2..255.
PERF_W, 16, width of the saturating stall-cycle counter.

Ports:
Clk  in  1  pipeline clock; all state updates on rising edge
Clrn  in  1  asynchronous active-low reset (clear)
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
ex_rn  in  5  destination register of the instruction in EX
ex_wreg  in  1  EX instruction writes the register file
ex_m2reg  in  1  EX instruction is a load
branch_taken  in  1  ID resolved a taken branch/jump this cycle
md_start  in  1  EX holds a multiply/divide op
perf_clr  in  1  synchronous clear of stall_cycles
pc_en  out  1  PC register enable
ifid_en  out  1  IF/ID register enable
ifid_flush  out  1  select NOP into IF/ID D input
idex_en  out  1  ID/EX register enable
idex_bubble  out  1  select zero control word into ID/EX D input
exmem_bubble  out  1  select zero control word into EX/MEM D input
md_busy  out  1  FSM is in MDWAIT
md_done  out  1  one-cycle pulse: MD result valid, EX advances this cycle
stall_cycles  out  PERF_W  count of cycles with pc_en=0, saturating

Behaviour:
- State: FSM {RUN, MDWAIT}, 8-bit down-counter cnt, stall_cycles. Clrn=0 forces asynchronously: state=RUN, cnt=0, stall_cycles=0.
- Outputs are combinational from state, cnt and inputs. While Clrn=0: all enables 0 and all bubble/flush/md_* 0.
- lu (load-use) = ex_wreg & ex_m2reg & (ex_rn!=0) & ((id_use_rs & ex_rn==id_rs) | (id_use_rt & ex_rn==id_rt)).
- md_stall = (state==RUN & md_start) | (state==MDWAIT & cnt!=0).
- Priority: md_stall > lu > branch_taken > normal.
- md_stall: pc_en=ifid_en=idex_en=0, exmem_bubble=1, others 0. lu and branch_taken are ignored, because ID is held and re-evaluates later.
- lu (no md_stall): pc_en=ifid_en=0, idex_en=1, idex_bubble=1. branch_taken is ignored the same cycle, since the branch stays in ID and reasserts.
- branch_taken alone: pc_en=ifid_en=idex_en=1, ifid_flush=1. Exactly one slot is squashed.
- Normal: all enables 1, all bubbles/flush 0.
- FSM transitions:
  - RUN & md_start: next MDWAIT, cnt<=MD_CYCLES-1.
  - MDWAIT & cnt!=0: cnt<=cnt-1; md_start is ignored.
  - MDWAIT & cnt==0: md_done=1, no stall, next RUN. md_start is ignored this cycle because the same op is still asserting it.
- Timing: one MD op gives exactly MD_CYCLES consecutive stall cycles, then one md_done cycle. A new md_start is honoured from the first RUN cycle after md_done.
- md_busy = (state==MDWAIT), including the md_done cycle.
- stall_cycles:
  - perf_clr=1: next value 0; clear has priority over increment.
  - else if pc_en==0 and value != all-ones: increment.
  - Holds at 2^PERF_W-1.
- Reset mid-MD: the FSM returns to RUN immediately. The partial op is discarded; md_done is not pulsed.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encoding (RUN=1'b0, MDWAIT=1'b1);
  - REG_ZERO=5'd0;
  - NOP control-word constant used by the bubble muxes.
- One sub-module: md_cycle_counter. Contains the loadable 8-bit down-counter with async active-low clear; ports Clk, Clrn, load, load_val, dec, zero.
- Hazard detection and output decode stay in the top level.

Test Plan:
- Load-use: ex_m2reg=1, ex_wreg=1, ex_rn=5, id_rs=5, id_use_rs=1 for one cycle -> pc_en=0, ifid_en=0, idex_bubble=1 that cycle; stall_cycles 0->1. Repeat with ex_rn=0 -> no stall.
- Branch: branch_taken=1 alone -> ifid_flush=1, pc_en=1, exactly one cycle. branch_taken plus a load-use hit -> stall outputs only, ifid_flush=0.
- MD op, MD_CYCLES=4: md_start held high from cycle t -> stall asserted cycles t..t+3; md_done=1 with all enables 1 at t+4; md_busy high t+1..t+4; stall_cycles +4.
- MD priority: during MDWAIT drive lu hit and branch_taken=1 -> only MD stall pattern (exmem_bubble=1, idex_bubble=0, ifid_flush=0).
- Reset mid-MD: drop Clrn at MDWAIT cnt=2, release -> state RUN, all outputs normal, stall_cycles=0, no md_done pulse.
- Saturation/clear: PERF_W=4, 20 lu-stall cycles -> stall_cycles holds 15. Assert perf_clr during a stall -> next value 0.
